// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the five-stage core. It drives the
// write enables and nop-insert controls of the FD, DX and XM latches so that
// the forwarding unit downstream only ever sees instruction pairs it can
// resolve. It handles three hazards:
//   * load-use stalls (one-cycle bubble into DX)
//   * taken-branch flushes (nop into FD and DX)
//   * multicycle mul/div: a small FSM launches the multdiv unit and freezes
//     the front of the pipeline until the result returns.
//
// Optional build macro:
//   HAZARD_MD_WATCHDOG_EN - adds a 6-bit watchdog that forces completion of a
//                           mul/div after MD_TIMEOUT cycles in MD_WAIT and
//                           pulses md_timeout. Undefined: MD_WAIT waits
//                           forever and md_timeout is tied low.
//
// Ports:
//   clock          in   pipeline clock, rising edge
//   reset          in   asynchronous, active-low reset
//   fd_inst[31:0]  in   instruction held in the FD latch
//   dx_inst[31:0]  in   instruction held in the DX latch
//   branch_taken   in   X-stage redirect resolved taken
//   md_ready       in   multdiv result valid
//   pc_en, fd_en, dx_en, xm_en  out  latch write enables
//   fd_flush       out  load nop into FD
//   dx_bubble      out  load nop into DX
//   xm_bubble      out  load nop into XM
//   md_start_mult  out  one-cycle multiply launch pulse
//   md_start_div   out  one-cycle divide launch pulse
//   md_result_sel  out  XM O-register takes the multdiv result
//   md_busy        out  FSM not IDLE
//   md_timeout     out  watchdog forced completion (one cycle, in MD_DONE)
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter logic [5:0] MD_TIMEOUT = 6'd40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_inst,
  input  logic [31:0] dx_inst,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_result_sel,
  output logic        md_busy,
  output logic        md_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } mdState_t;

  // Opcodes (inst[31:27]) and R-type ALU ops (inst[6:2])
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  mdState_t stateReg, stateNext;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [4:0] dxOp, dxRd, dxAluOp;
  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic       dxIsMul, dxIsDiv, dxIsLw;
  logic       fdReadsRs, fdReadsRt, fdReadsRd;
  logic       loadUse;

  assign dxOp    = dx_inst[31:27];
  assign dxRd    = dx_inst[26:22];
  assign dxAluOp = dx_inst[6:2];
  assign fdOp    = fd_inst[31:27];
  assign fdRd    = fd_inst[26:22];
  assign fdRs    = fd_inst[21:17];
  assign fdRt    = fd_inst[16:12];

  assign dxIsMul = (dxOp == OP_RTYPE) && (dxAluOp == ALU_MUL);
  assign dxIsDiv = (dxOp == OP_RTYPE) && (dxAluOp == ALU_DIV);
  assign dxIsLw  = (dxOp == OP_LW);

  // Which source fields the FD instruction actually reads. sw reads its rd
  // too, but only as store data, which the memory-data bypass already covers,
  // so sw only counts through rs here.
  assign fdReadsRs = !((fdOp == OP_J) || (fdOp == OP_JAL) ||
                       (fdOp == OP_SETX) || (fdOp == OP_BEX));
  assign fdReadsRt = (fdOp == OP_RTYPE);
  assign fdReadsRd = (fdOp == OP_BNE) || (fdOp == OP_BLT) || (fdOp == OP_JR);

  assign loadUse = dxIsLw && (dxRd != 5'd0) &&
                   ((fdReadsRs && (fdRs == dxRd)) ||
                    (fdReadsRt && (fdRt == dxRd)) ||
                    (fdReadsRd && (fdRd == dxRd)));

  // --------------------------------------------------------------------------
  // Watchdog counter (optional)
  // --------------------------------------------------------------------------
`ifdef HAZARD_MD_WATCHDOG_EN
  logic [5:0] wdCountReg;

  // Cleared on entry to MD_WAIT, counts every MD_WAIT cycle without md_ready.
  // It holds on a genuine md_ready exit, so reaching MD_TIMEOUT in MD_DONE
  // can only mean the watchdog forced the completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdCountReg <= 6'd0;
    end else if ((stateReg == IDLE) && (stateNext == MD_WAIT)) begin
      wdCountReg <= 6'd0;
    end else if ((stateReg == MD_WAIT) && !md_ready) begin
      wdCountReg <= wdCountReg + 6'd1;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^MD_TIMEOUT;
`endif

  // Instruction fields this block never looks at.
  logic unusedBits;
  assign unusedBits = ^{fd_inst[11:0], dx_inst[21:7], dx_inst[1:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    stateNext     = stateReg;
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    dx_en         = 1'b1;
    xm_en         = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    xm_bubble     = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    md_result_sel = 1'b0;
    md_timeout    = 1'b0;

    // While reset is held low the outputs stay at their reset values even if
    // a mul/div sits in DX, so no launch pulse leaks out during reset.
    if (!reset) begin
      stateNext = IDLE;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (dxIsMul || dxIsDiv) begin
            md_start_mult = dxIsMul;
            md_start_div  = dxIsDiv;
            pc_en         = 1'b0;
            fd_en         = 1'b0;
            dx_en         = 1'b0;
            xm_bubble     = 1'b1;
            stateNext     = MD_WAIT;
          end else if (branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (loadUse) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end
        end

        MD_WAIT: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          if (md_ready) begin
            stateNext = MD_DONE;
          end
`ifdef HAZARD_MD_WATCHDOG_EN
          // Counter reads MD_TIMEOUT-1 during the MD_TIMEOUT-th wait cycle.
          else if (wdCountReg == (MD_TIMEOUT - 6'd1)) begin
            stateNext = MD_DONE;
          end
`endif
        end

        MD_DONE: begin
          // DX still holds the mul/div here; returning to IDLE unconditionally
          // keeps it from being relaunched while its successor loads.
          md_result_sel = 1'b1;
          stateNext     = IDLE;
`ifdef HAZARD_MD_WATCHDOG_EN
          md_timeout    = (wdCountReg == MD_TIMEOUT);
`endif
        end

        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign md_busy = (stateReg != IDLE);

endmodule
